alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage ALU that consumes the 4-bit ALU control code and shift flag produced by the ALU decoder and computes the result.

- Logic and arithmetic ops complete in one cycle.
- Shifts and rotates run on an iterative one-bit-per-cycle shifter, which keeps area small.
- A valid/ready handshake throttles the issue logic while a multi-cycle shift is in flight.
- The registered result, zero flag and illegal-op flag feed the writeback mux and the branch-compare logic.

## Interface

Parameters:
- WIDTH, 32, operand/result width.
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- i_clk  input  1  clock; all state changes on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_valid  input  1  operation request; accepted on an edge where i_valid && o_ready
- o_ready  output  1  unit idle, can accept
- i_alu_control  input  4  ALU control code from the decoder
- i_shift  input  1  shift-class flag from the decoder
- i_a  input  WIDTH  operand A (rs)
- i_b  input  WIDTH  operand B (rt or immediate); the shift/rotate source
- i_shamt  input  SHW  shift amount
- o_valid  output  1  one-cycle pulse; result fields valid
- o_result  output  WIDTH  registered result
- o_zero  output  1  o_result == 0
- o_illegal  output  1  accepted op was undefined or inconsistent

## Operation

Control codes:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR.
- 0110 SUB, 0111 SLT (signed; result 1 or 0).
- 1000 SLL, 1001 SRL, 1010 SRA, 1011 ROR, 1100 ROL.

Arithmetic rules:
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- Shift/rotate source is i_b and amount is i_shamt; i_a is ignored for shifts.

Illegal ops:
- Any other code, a code containing X/Z, or i_shift inconsistent with code bit 3 is illegal.
- Illegal op: o_result=0, o_zero=1, o_illegal=1, latency 1.

State machine (IDLE, SHIFT):
- IDLE, accept of a non-shift, illegal, or shamt=0 op:
  - Register the result; o_valid=1 in the next cycle; stay IDLE.
  - shamt=0 returns i_b unchanged.
- IDLE, accept of a shift with shamt=N>0:
  - Load work=i_b, cnt=N, latch the op; go to SHIFT.
- SHIFT, each edge:
  - work shifts one position: SLL fills 0, SRL fills 0, SRA fills the MSB, ROR/ROL wrap the end bit.
  - cnt decrements.
  - On the edge where cnt==1, return to IDLE, drive o_result=shifted work, and pulse o_valid.
- o_ready = (state==IDLE).
- i_valid and operands are ignored while in SHIFT.

## Timing

Reset values:
- Reset is synchronous: at any edge with i_rst_n=0, state=IDLE, cnt=0.
- o_valid=0, o_result=0, o_zero=1, o_illegal=0; o_ready=1 in the cycle after.
- Reset mid-shift aborts the operation with no o_valid.

Latency:
- Non-shift, illegal, or shamt=0: 1 cycle; back-to-back accepts every cycle give one o_valid per cycle.
- Shift with N>0: o_valid in the cycle after edge E0+N, where E0 is the accept edge; o_ready is low for N cycles.
- o_ready rises in the same cycle as o_valid, so the next accept can occur on that edge.

Output behaviour:
- o_valid is high for exactly one cycle.
- o_result/o_zero/o_illegal hold their values until the next completion.

## Structure

- Package alu_pkg:
  - ALU control code localparams (ALU_AND … ALU_ROL).
  - State encoding (ST_IDLE, ST_SHIFT).
  - WIDTH default.
- The decoder is to import the same codes from alu_pkg.
- One sub-module, alu_comb: purely combinational single-cycle ops (AND/OR/ADD/XOR/NOR/SUB/SLT plus the illegal detect).
- The FSM, counter and iterative shifter live in alu_exec_unit.

## Test plan

- Reset: hold i_rst_n=0 while i_valid=1 -> o_ready=1, o_valid=0, o_result=0, o_zero=1.
- Back-to-back single-cycle ops, one accept per edge:
  - ADD a=0xFFFFFFFF, b=1 -> 0x00000000, zero=1.
  - SUB a=5, b=7 -> 0xFFFFFFFE.
  - SLT a=0xFFFFFFFF, b=1 -> 1.
  - Expect 3 consecutive o_valid pulses, latency 1 each.
- SRA b=0x80000000, shamt=4 -> o_ready low 4 cycles, o_valid 4 cycles after accept, result 0xF8000000.
- Rotates, no fill loss:
  - ROL b=0x80000001, shamt=1 -> 0x00000003.
  - ROR b=0x00000001, shamt=31 -> 0x00000002.
- SLL b=0x1234, shamt=0 -> latency 1, result 0x1234.
- Error and abort cases:
  - Code 0101 -> o_illegal=1, result 0.
  - Code 1000 with i_shift=0 -> o_illegal=1, result 0.
  - Reset asserted 2 cycles into SLL shamt=10 -> no o_valid, o_ready=1 after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, FSM state encoding and default datapath width
// for the execute-stage ALU and the decoder that feeds it.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_ROR = 4'b1011;
    localparam logic [3:0] ALU_ROL = 4'b1100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations plus detection of undefined, unknown or
// shift-flag-inconsistent control codes.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [3:0]       alu_control,
    input  logic             shift,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_control)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROR, ALU_ROL: result = '0;
            default: illegal = 1'b1;
        endcase
        // Code bit 3 marks the shift class, so the decoder flag must agree with it.
        if ($isunknown({alu_control, shift}) || (shift != alu_control[3])) begin
            illegal = 1'b1;
        end
        if (illegal) begin
            result = '0;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle logic/arithmetic via alu_comb, and an
// iterative one-bit-per-cycle shifter for shifts and rotates.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_alu_control,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [SHW-1:0]   i_shamt,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_illegal
);

    alu_state_t       state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] comb_result;
    logic             comb_illegal;
    logic [WIDTH-1:0] work_next;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .alu_control (i_alu_control),
        .shift       (i_shift),
        .a           (i_a),
        .b           (i_b),
        .result      (comb_result),
        .illegal     (comb_illegal)
    );

    always_comb begin
        case (op_q)
            ALU_SLL: work_next = {work_q[WIDTH-2:0], 1'b0};
            ALU_SRL: work_next = {1'b0, work_q[WIDTH-1:1]};
            ALU_SRA: work_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            ALU_ROR: work_next = {work_q[0], work_q[WIDTH-1:1]};
            ALU_ROL: work_next = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            default: work_next = work_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        op_d      = op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (comb_illegal) begin
                        result_d  = '0;
                        zero_d    = 1'b1;
                        illegal_d = 1'b1;
                        valid_d   = 1'b1;
                    end else if (!i_shift) begin
                        result_d  = comb_result;
                        zero_d    = (comb_result == '0);
                        illegal_d = 1'b0;
                        valid_d   = 1'b1;
                    end else if (i_shamt == '0) begin
                        result_d  = i_b;
                        zero_d    = (i_b == '0);
                        illegal_d = 1'b0;
                        valid_d   = 1'b1;
                    end else begin
                        work_d  = i_b;
                        cnt_d   = i_shamt;
                        op_d    = i_alu_control;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = work_next;
                cnt_d  = cnt_q - SHW'(1);
                // The last step's shifted value goes straight to the result register.
                if (cnt_q == SHW'(1)) begin
                    state_d   = ST_IDLE;
                    result_d  = work_next;
                    zero_d    = (work_next == '0);
                    illegal_d = 1'b0;
                    valid_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            op_q      <= ALU_AND;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            op_q      <= op_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
        end
    end

    assign o_ready   = (state_q == ST_IDLE);
    assign o_valid   = valid_q;
    assign o_result  = result_q;
    assign o_zero    = zero_q;
    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed results.
module tb_alu_exec_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_alu_control;
    logic        i_shift;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [4:0]  i_shamt;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_illegal;

    int checks = 0;
    int errors = 0;
    int cycles;
    int pulses;

    alu_exec_unit dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_alu_control (i_alu_control),
        .i_shift       (i_shift),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_shamt       (i_shamt),
        .o_valid       (o_valid),
        .o_result      (o_result),
        .o_zero        (o_zero),
        .o_illegal     (o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] ctrl, input logic shift,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] shamt);
        i_valid       = valid;
        i_alu_control = ctrl;
        i_shift       = shift;
        i_a           = a;
        i_b           = b;
        i_shamt       = shamt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Steps until o_valid is seen, giving up after a fixed budget.
    task automatic waitValid(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_valid && n < budget);
    endtask

    initial begin
        i_rst_n = 1'b0;
        applyStimulus(1'b1, 4'b0010, 1'b0, 32'h1, 32'h2, 5'd0);
        step();
        step();
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_result", o_result, 32'h0);
        checkOutput("rst_zero", 32'(o_zero), 32'd1);
        checkOutput("rst_illegal", 32'(o_illegal), 32'd0);

        i_rst_n = 1'b1;
        applyStimulus(1'b1, 4'b0010, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0);
        step();
        checkOutput("add_valid", 32'(o_valid), 32'd1);
        checkOutput("add_result", o_result, 32'h0);
        checkOutput("add_zero", 32'(o_zero), 32'd1);
        applyStimulus(1'b1, 4'b0110, 1'b0, 32'd5, 32'd7, 5'd0);
        step();
        checkOutput("sub_valid", 32'(o_valid), 32'd1);
        checkOutput("sub_result", o_result, 32'hFFFF_FFFE);
        checkOutput("sub_zero", 32'(o_zero), 32'd0);
        applyStimulus(1'b1, 4'b0111, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0);
        step();
        checkOutput("slt_valid", 32'(o_valid), 32'd1);
        checkOutput("slt_result", o_result, 32'h1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        checkOutput("idle_valid", 32'(o_valid), 32'd0);
        checkOutput("idle_hold", o_result, 32'h1);

        applyStimulus(1'b1, 4'b0000, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0);
        step();
        checkOutput("and_result", o_result, 32'h0F0F_0000);
        applyStimulus(1'b1, 4'b0001, 1'b0, 32'hF000_0000, 32'h0000_000F, 5'd0);
        step();
        checkOutput("or_result", o_result, 32'hF000_000F);
        applyStimulus(1'b1, 4'b0011, 1'b0, 32'h0000_00F0, 32'h0000_00FF, 5'd0);
        step();
        checkOutput("xor_result", o_result, 32'h0000_000F);
        applyStimulus(1'b1, 4'b0100, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        checkOutput("nor_result", o_result, 32'hFFFF_FFFF);

        applyStimulus(1'b1, 4'b1010, 1'b1, 32'h0, 32'h8000_0000, 5'd4);
        step();
        checkOutput("sra_ready_e0", 32'(o_ready), 32'd0);
        checkOutput("sra_valid_e0", 32'(o_valid), 32'd0);
        applyStimulus(1'b1, 4'b0010, 1'b0, 32'h1, 32'h1, 5'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            checkOutput("sra_ready_busy", 32'(o_ready), 32'd0);
            checkOutput("sra_valid_busy", 32'(o_valid), 32'd0);
        end
        step();
        checkOutput("sra_valid", 32'(o_valid), 32'd1);
        checkOutput("sra_ready", 32'(o_ready), 32'd1);
        checkOutput("sra_result", o_result, 32'hF800_0000);
        checkOutput("sra_zero", 32'(o_zero), 32'd0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        checkOutput("sra_pulse_end", 32'(o_valid), 32'd0);
        checkOutput("sra_hold", o_result, 32'hF800_0000);

        applyStimulus(1'b1, 4'b1100, 1'b1, 32'h0, 32'h8000_0001, 5'd1);
        step();
        checkOutput("rol_ready_e0", 32'(o_ready), 32'd0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        checkOutput("rol_valid", 32'(o_valid), 32'd1);
        checkOutput("rol_result", o_result, 32'h0000_0003);

        applyStimulus(1'b1, 4'b1011, 1'b1, 32'h0, 32'h0000_0001, 5'd31);
        step();
        applyStimulus(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 5'd0);
        waitValid(40, cycles);
        checkOutput("ror_latency", 32'(cycles), 32'd31);
        checkOutput("ror_result", o_result, 32'h0000_0002);

        applyStimulus(1'b1, 4'b1001, 1'b1, 32'h0, 32'h0000_00F0, 5'd4);
        step();
        applyStimulus(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 5'd0);
        waitValid(10, cycles);
        checkOutput("srl_latency", 32'(cycles), 32'd4);
        checkOutput("srl_result", o_result, 32'h0000_000F);

        applyStimulus(1'b1, 4'b1000, 1'b1, 32'h0, 32'h0000_1234, 5'd0);
        step();
        checkOutput("sll0_valid", 32'(o_valid), 32'd1);
        checkOutput("sll0_ready", 32'(o_ready), 32'd1);
        checkOutput("sll0_result", o_result, 32'h0000_1234);

        applyStimulus(1'b1, 4'b0101, 1'b0, 32'd5, 32'd3, 5'd0);
        step();
        checkOutput("ill0101_valid", 32'(o_valid), 32'd1);
        checkOutput("ill0101_flag", 32'(o_illegal), 32'd1);
        checkOutput("ill0101_result", o_result, 32'h0);
        checkOutput("ill0101_zero", 32'(o_zero), 32'd1);
        applyStimulus(1'b1, 4'b0010, 1'b0, 32'd2, 32'd3, 5'd0);
        step();
        checkOutput("legal_clears", 32'(o_illegal), 32'd0);
        checkOutput("legal_result", o_result, 32'd5);
        applyStimulus(1'b1, 4'b1000, 1'b0, 32'h0, 32'h0000_1234, 5'd3);
        step();
        checkOutput("ill_noshift_flag", 32'(o_illegal), 32'd1);
        checkOutput("ill_noshift_result", o_result, 32'h0);
        checkOutput("ill_noshift_ready", 32'(o_ready), 32'd1);
        applyStimulus(1'b1, 4'b0010, 1'b1, 32'd2, 32'd3, 5'd0);
        step();
        checkOutput("ill_addshift_flag", 32'(o_illegal), 32'd1);
        checkOutput("ill_addshift_result", o_result, 32'h0);

        applyStimulus(1'b1, 4'b1000, 1'b1, 32'h0, 32'h0000_0001, 5'd10);
        step();
        applyStimulus(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        step();
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        checkOutput("abort_ready", 32'(o_ready), 32'd1);
        checkOutput("abort_valid", 32'(o_valid), 32'd0);
        checkOutput("abort_result", o_result, 32'h0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (o_valid) pulses++;
        end
        checkOutput("abort_no_pulse", 32'(pulses), 32'd0);
        checkOutput("abort_ready_after", 32'(o_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
